// File: rtl/slave_attack_responder.sv
// Slave-side attack link endpoint: parses load/attack frames, keeps ship and attacked maps, returns a reply byte.
// Optional ATTACK_TIMEOUT_EN: abandons a partial frame after TIMEOUT_CYCLES idle cycles.
module slave_attack_responder #(
    parameter int          TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  HDR_LOAD       = 8'hA5,
    parameter logic [7:0]  HDR_ATK        = 8'h3C
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    output logic [15:0] ship_map,
    output logic [15:0] hit_map,
    output logic [4:0]  lives,
    output logic        all_sunk,
    output logic        frame_err
);

    typedef enum logic [2:0] {IDLE, GET_HI, GET_LO, EVAL, RESP} state_t;

    typedef struct packed {
        logic       ack;
        logic       hit;
        logic       dup;
        logic [4:0] lives;
    } reply_t;

    localparam logic [7:0] REPLY_LOAD = 8'h5A;
    localparam logic [7:0] REPLY_NAK  = 8'hEE;

    state_t      state, state_nxt;
    logic        is_load;
    logic [15:0] payload;
    logic [15:0] attacked;
    logic        in_payload;
    logic        hdr_ok;
    logic        timeout;

    assign in_payload = (state == GET_HI) || (state == GET_LO);
    assign hdr_ok     = rx_valid && ((rx_byte == HDR_LOAD) || (rx_byte == HDR_ATK));

`ifdef ATTACK_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] idle_cnt;

    // Counts idle cycles between payload bytes; any byte or leaving the payload states restarts it.
    always_ff @(posedge clk) begin
        if (clr || !in_payload || rx_valid)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + 1'b1;
    end

    assign timeout = in_payload && !rx_valid && (idle_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (clr) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hdr_ok) state_nxt = GET_HI;
            GET_HI:  if (timeout) state_nxt = IDLE; else if (rx_valid) state_nxt = GET_LO;
            GET_LO:  if (timeout) state_nxt = IDLE; else if (rx_valid) state_nxt = EVAL;
            EVAL:    state_nxt = RESP;
            RESP:    if (tx_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Attack scoring, evaluated against the registered payload during EVAL.
    logic        onehot;
    logic [15:0] atk_next;
    reply_t      reply;

    always_comb begin
        onehot      = (payload != 16'h0) && ((payload & (payload - 16'h1)) == 16'h0);
        atk_next    = attacked | payload;
        reply.ack   = 1'b1;
        reply.hit   = |(payload & ship_map & ~attacked);
        reply.dup   = |(payload & attacked);
        reply.lives = 5'($countones(ship_map & ~atk_next));
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            is_load   <= 1'b0;
            payload   <= '0;
            ship_map  <= '0;
            attacked  <= '0;
            tx_byte   <= '0;
            tx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= timeout;
            case (state)
                IDLE:   if (hdr_ok) is_load <= (rx_byte == HDR_LOAD);
                GET_HI: if (rx_valid) payload[15:8] <= rx_byte;
                GET_LO: if (rx_valid) payload[7:0]  <= rx_byte;
                EVAL: begin
                    tx_valid <= 1'b1;
                    if (is_load) begin
                        ship_map <= payload;
                        attacked <= '0;
                        tx_byte  <= REPLY_LOAD;
                    end else if (!onehot) begin
                        tx_byte   <= REPLY_NAK;
                        frame_err <= 1'b1;
                    end else begin
                        attacked <= atk_next;
                        tx_byte  <= reply;
                    end
                end
                RESP:    if (tx_ready) tx_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign hit_map  = ship_map & attacked;
    assign lives    = 5'($countones(ship_map & ~attacked));
    assign all_sunk = (lives == 5'd0) && (ship_map != 16'h0);

endmodule

// File: tb/tb_slave_attack_responder.sv
// Scoreboarded random/directed bench for slave_attack_responder against a map-level game model.
module tb_slave_attack_responder;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        clr, rx_valid, tx_ready;
    logic [7:0]  rx_byte;
    logic [7:0]  tx_byte;
    logic        tx_valid, all_sunk, frame_err;
    logic [15:0] ship_map, hit_map;
    logic [4:0]  lives;

    always #5 clk = ~clk;

    slave_attack_responder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .clr(clr), .rx_byte(rx_byte), .rx_valid(rx_valid), .tx_ready(tx_ready),
        .tx_byte(tx_byte), .tx_valid(tx_valid), .ship_map(ship_map), .hit_map(hit_map),
        .lives(lives), .all_sunk(all_sunk), .frame_err(frame_err)
    );

    typedef struct {
        logic [7:0]  b;
        logic [15:0] ship;
        logic [15:0] hm;
        int          lv;
        bit          sunk;
    } exp_t;

    exp_t        q[$];
    int          total = 0, bad = 0, hs_cnt = 0;
    logic [15:0] m_ship = 16'h0, m_atk = 16'h0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", n, act, exp, $time);
        end
    endtask

    // Game model: the map state after a frame and the reply the slave should give.
    task automatic model(input logic [7:0] hdr, input logic [15:0] pay);
        exp_t e;
        int   ones, lv;
        bit   hit, dup;
        ones = $countones(pay);
        if (hdr == 8'hA5) begin
            m_ship = pay;
            m_atk  = 16'h0;
            e.b    = 8'h5A;
        end else if (ones != 1) begin
            e.b = 8'hEE;
        end else begin
            dup   = (pay & m_atk) != 0;
            hit   = (pay & m_ship & ~m_atk) != 0;
            m_atk = m_atk | pay;
            lv    = $countones(m_ship & ~m_atk);
            e.b   = {1'b1, hit, dup, 5'(lv)};
        end
        e.ship = m_ship;
        e.hm   = m_ship & m_atk;
        e.lv   = $countones(m_ship & ~m_atk);
        e.sunk = (e.lv == 0) && (m_ship != 0);
        q.push_back(e);
    endtask

    // Monitor: compares every presented reply with the scoreboard head.
    initial begin
        bit prev_vld;
        prev_vld = 1'b0;
        forever begin
            @(negedge clk);
            if (clr) begin
                prev_vld = 1'b0;
            end else begin
                if (tx_valid) begin
                    if (q.size() == 0) begin
                        chk("unexpected_reply", {24'h0, tx_byte}, 32'hFFFF_FFFF);
                    end else begin
                        chk("tx_byte", tx_byte, q[0].b);
                        if (!prev_vld) begin
                            chk("frame_err", frame_err, q[0].b == 8'hEE);
                            chk("ship_map", ship_map, q[0].ship);
                            chk("hit_map", hit_map, q[0].hm);
                            chk("lives", lives, q[0].lv);
                            chk("all_sunk", all_sunk, q[0].sunk);
                        end
                        if (tx_ready) begin
                            void'(q.pop_front());
                            hs_cnt++;
                        end
                    end
                end
`ifndef ATTACK_TIMEOUT_EN
                else if (frame_err) chk("stray_frame_err", frame_err, 1'b0);
`endif
                prev_vld = tx_valid;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_byte  = 8'($urandom);
    endtask

    task automatic gap(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic frame(input logic [7:0] hdr, input logic [15:0] pay, input int hold, input bit inject);
        int start;
        bit done;
        model(hdr, pay);
        send_byte(hdr);
        gap($urandom_range(0, 2));
        send_byte(pay[15:8]);
        gap($urandom_range(0, 2));
        send_byte(pay[7:0]);
        @(negedge clk);
        chk("lat_early", tx_valid, 1'b0);
        @(negedge clk);
        chk("lat_k1", tx_valid, 1'b1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            rx_byte  = 8'h3C;
            rx_valid = inject && (i == 1);
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        start = hs_cnt;
        done  = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            done = (hs_cnt != start);
        end
        if (!done) chk("handshake_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        tx_ready = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        @(negedge clk);
        chk({tag, "_tx_byte"}, tx_byte, 8'h00);
        chk({tag, "_tx_valid"}, tx_valid, 1'b0);
        chk({tag, "_ship_map"}, ship_map, 16'h0);
        chk({tag, "_hit_map"}, hit_map, 16'h0);
        chk({tag, "_lives"}, lives, 5'd0);
        chk({tag, "_all_sunk"}, all_sunk, 1'b0);
        chk({tag, "_frame_err"}, frame_err, 1'b0);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        q.delete();
        m_ship = 16'h0;
        m_atk  = 16'h0;
    endtask

    initial begin
        logic [15:0] sink[7];
        logic [7:0]  junk;
        logic [15:0] pay;
        int          r;
        sink = '{16'h2000, 16'h0002, 16'h0004, 16'h0020, 16'h0040, 16'h0080, 16'h1000};
        clr = 1'b1; rx_valid = 1'b0; tx_ready = 1'b0; rx_byte = 8'h00;
        @(posedge clk); @(posedge clk); #1;
        clr = 1'b0;
        check_reset_vals("rst");
        @(posedge clk); #1;

        // Attack before any load, then the directed game sequence.
        frame(8'h3C, 16'h0100, 0, 1'b0);
        frame(8'h3C, 16'h0100, 0, 1'b0);
        frame(8'hA5, 16'h30E6, 0, 1'b0);
        frame(8'h3C, 16'h2000, 1, 1'b0);
        frame(8'h3C, 16'h2000, 0, 1'b0);
        frame(8'h3C, 16'h8000, 0, 1'b0);
        frame(8'h3C, 16'h3000, 2, 1'b0);
        frame(8'h3C, 16'h0000, 0, 1'b0);
        foreach (sink[i]) frame(8'h3C, sink[i], 0, 1'b0);
        @(negedge clk);
        chk("plan_all_sunk", all_sunk, 1'b1);
        @(posedge clk); #1;
        frame(8'hA5, 16'h0001, 5, 1'b1);
        @(negedge clk);
        chk("plan_reload_lives", lives, 5'd1);
        chk("plan_reload_sunk", all_sunk, 1'b0);
        @(posedge clk); #1;

        // Randomized game traffic with junk headers and held tx_ready.
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                junk = 8'($urandom);
                if (junk == 8'hA5 || junk == 8'h3C) junk = 8'h00;
                send_byte(junk);
                gap(1);
            end else if (r == 1) begin
                frame(8'hA5, 16'($urandom) & 16'($urandom), $urandom_range(0, 4), 1'($urandom));
            end else begin
                pay = (r == 2) ? 16'($urandom) & 16'($urandom) : 16'h1 << $urandom_range(0, 15);
                frame(8'h3C, pay, $urandom_range(0, 4), 1'($urandom));
            end
        end

        // Reset in the middle of a frame, then a normal frame.
        send_byte(8'h3C);
        send_byte(8'h20);
        do_clr();
        check_reset_vals("clr_mid");
        @(posedge clk); #1;
        frame(8'h3C, 16'h0004, 0, 1'b0);

        // Reset while a reply is pending: the reply is discarded.
        frame(8'hA5, 16'h00F0, 0, 1'b0);
        model(8'h3C, 16'h0010);
        send_byte(8'h3C); send_byte(8'h00); send_byte(8'h10);
        gap(3);
        do_clr();
        check_reset_vals("clr_resp");
        @(posedge clk); #1;

`ifdef ATTACK_TIMEOUT_EN
        begin
            int pulses, vlds;
            pulses = 0; vlds = 0;
            send_byte(8'h3C);
            send_byte(8'h20);
            for (int i = 0; i < TO + 4; i++) begin
                @(negedge clk);
                if (frame_err) pulses++;
                if (tx_valid) vlds++;
            end
            chk("timeout_err_pulses", pulses, 1);
            chk("timeout_no_reply", vlds, 0);
            @(posedge clk); #1;
            frame(8'h3C, 16'h0004, 0, 1'b0);
        end
`endif

        gap(3);
        chk("scoreboard_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/slave_attack_responder.md
# slave_attack_responder

Slave-board endpoint of the master/slave attack link. It receives byte frames from the master's link (ship-map loads and single-cell attacks) and keeps the defending player's ship map and attacked-cell map. For each frame it scores the attack and returns a one-byte reply (hit, duplicate and remaining lives) to the link transmitter. It sits between the slave's UART receiver/transmitter byte ports and its display logic.

## Interface
- TIMEOUT_CYCLES, 100000, maximum idle cycles between bytes of one frame (compiled only with the timeout macro).
- HDR_LOAD, 8'hA5, header byte of a load frame.
- HDR_ATK, 8'h3C, header byte of an attack frame.

Ports:
- clk  in  1  system clock; one clock domain.
- clr  in  1  reset; synchronous, active-high.
- rx_byte  in  8  received byte; valid only while rx_valid is high.
- rx_valid  in  1  one-cycle strobe per received byte.
- tx_ready  in  1  transmitter accepts tx_byte this cycle.
- tx_byte  out  8  reply byte; stable while tx_valid is high.
- tx_valid  out  1  reply pending; held until the tx_valid&tx_ready handshake.
- ship_map  out  16  stored ship positions.
- hit_map  out  16  ship_map & attacked.
- lives  out  5  popcount(ship_map & ~attacked), range 0..16.
- all_sunk  out  1  lives==0 while ship_map!=0.
- frame_err  out  1  one-cycle pulse on a dropped or malformed frame.

## Operation
- Frame format: header byte, then payload high byte, then payload low byte (MSB first). The payload is a 16-bit cell mask.
- Load frame:
  - ship_map <= payload; attacked <= 0.
  - Reply 8'h5A.
  - Accepted in any game state, including all_sunk; this restarts the game.
- Attack frame, payload not exactly one-hot (zero or two or more bits set):
  - Reply NAK 8'hEE and pulse frame_err.
  - No register change.
- Attack frame, one-hot payload:
  - dup = |(payload & attacked).
  - hit = |(payload & ship_map & ~attacked).
  - attacked <= attacked | payload.
  - Reply {1'b1, hit, dup, lives_after[4:0]}, where lives_after is the value after the update.
- Attack before any load: ship_map=0, so the reply is a miss with lives 0 (8'h80, or 8'hA0 on a repeated cell).
- A header byte that is neither HDR_LOAD nor HDR_ATK is silently ignored; the FSM stays in IDLE.
- States:
  - IDLE: a valid header goes to GET_HI.
  - GET_HI: a byte goes to GET_LO.
  - GET_LO: a byte goes to EVAL.
  - EVAL: one cycle; goes to RESP.
  - RESP: goes back to IDLE on tx_ready.
- Bytes arriving in EVAL or RESP are dropped, with no frame_err (the master is half-duplex).

## Timing
- Reset values:
  - tx_byte=0, tx_valid=0, ship_map=0, hit_map=0, lives=0, all_sunk=0, frame_err=0.
  - attacked=0, FSM=IDLE.
- Latency:
  - The last payload byte is captured on edge k; the EVAL edge is k+1.
  - The map update, tx_byte and tx_valid=1 all register on edge k+1.
  - tx_valid is therefore visible 2 cycles after rx_valid of the last byte.
- Handshake: tx_valid may be asserted before tx_ready. Completion is the first edge with tx_ready=1, after which tx_valid=0 on the next cycle.
- A back-to-back frame header is accepted in the cycle immediately after the handshake.
- lives, hit_map and all_sunk are combinational from registers and update on the same edge as the maps.
- clr mid-frame or mid-RESP aborts everything to reset values on the next edge. The pending reply is discarded.

## Configuration
- ATTACK_TIMEOUT_EN defined:
  - A counter runs in GET_HI and GET_LO and restarts on each byte.
  - On reaching TIMEOUT_CYCLES without a byte, the partial frame is discarded, frame_err pulses, the FSM returns to IDLE and no reply is sent.
- ATTACK_TIMEOUT_EN undefined: the counter is absent and GET_HI/GET_LO wait indefinitely.

## Test plan
- Load A5,30,E6 → reply 8'h5A; ship_map=16'h30E6, lives=7, hit_map=0.
- Attack 3C,20,00 after that load → reply 8'hC6; hit_map=16'h2000, lives=6. Repeat the same frame → reply 8'hA6, lives unchanged.
- Attack 3C,80,00 (empty cell) → reply 8'h86. Attack 3C,30,00 (two bits) → reply 8'hEE with a frame_err pulse; attacked unchanged.
- Attack all seven ship cells of 16'h30E6 → last reply 8'hC0; all_sunk=1. A following load A5,00,01 → reply 8'h5A, all_sunk=0, lives=1.
- Hold tx_ready=0 for 5 cycles after a reply is raised, injecting rx byte 8'h3C meanwhile → tx_byte stable, tx_valid high, the injected byte ignored. A single tx_ready pulse completes the handshake and the FSM returns to IDLE.
- With ATTACK_TIMEOUT_EN and TIMEOUT_CYCLES=16: send 3C,20 then idle 16 cycles → frame_err pulse, no tx_valid. Next full frame 3C,00,04 is scored normally. Additionally, clr asserted in GET_LO restores all reset values.
